// File: rtl/i2s_rx_pkg.sv
// ---------------------------------------------------------------------------
// i2s_rx_pkg
// Shared types and constants for the I2S receive deserialiser.
//   state_e     : capture FSM states (SYNC, SHIFT, DONE)
//   CHAN_LEFT   : lrclk level of the left slot (also tlast value of left beats)
//   CHAN_RIGHT  : lrclk level of the right slot
//   AXIS_WIDTH  : output stream width, fixed at 32
//   TSTRB_ALL   : tstrb value, every byte of every beat is valid
// ---------------------------------------------------------------------------
package i2s_rx_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic       CHAN_LEFT  = 1'b0;
    localparam logic       CHAN_RIGHT = 1'b1;
    localparam int         AXIS_WIDTH = 32;
    localparam logic [3:0] TSTRB_ALL  = 4'hF;

endpackage

// File: rtl/i2s_rx_sync.sv
// ---------------------------------------------------------------------------
// i2s_rx_sync
// Brings the three asynchronous I2S pins into the AXIS clock domain and
// detects bit-clock rising edges.
//   clk_i        : AXIS clock
//   rst_ni       : synchronous active-low reset
//   bclk_i       : raw I2S bit clock pin
//   lrclk_i      : raw I2S word select pin
//   sdata_i      : raw I2S serial data pin
//   bclk_rise_o  : one-cycle pulse, synchronised bclk went 0 -> 1
//   lrclk_s_o    : synchronised word select
//   sdata_s_o    : synchronised serial data
// All three pins see the same two-stage delay, so lrclk_s_o/sdata_s_o are
// aligned with bclk_rise_o exactly as they were at the pins.
// ---------------------------------------------------------------------------
module i2s_rx_sync
    import i2s_rx_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic bclk_i,
    input  logic lrclk_i,
    input  logic sdata_i,
    output logic bclk_rise_o,
    output logic lrclk_s_o,
    output logic sdata_s_o
);

    logic [1:0] bclk_ff_q;
    logic [1:0] lrclk_ff_q;
    logic [1:0] sdata_ff_q;
    logic       bclk_prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            bclk_ff_q   <= '0;
            lrclk_ff_q  <= '0;
            sdata_ff_q  <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            bclk_ff_q   <= {bclk_ff_q[0], bclk_i};
            lrclk_ff_q  <= {lrclk_ff_q[0], lrclk_i};
            sdata_ff_q  <= {sdata_ff_q[0], sdata_i};
            bclk_prev_q <= bclk_ff_q[1];
        end
    end

    assign bclk_rise_o = bclk_ff_q[1] & ~bclk_prev_q;
    assign lrclk_s_o   = lrclk_ff_q[1];
    assign sdata_s_o   = sdata_ff_q[1];

endmodule

// File: rtl/i2s_rx_deserializer.sv
// ---------------------------------------------------------------------------
// i2s_rx_deserializer
// I2S receiver: oversamples bclk/lrclk/sdata in the AXIS clock domain,
// captures DATA_BITS per slot MSB-first (standard one-bit I2S delay) and
// emits sign-extended 32-bit samples as an AXI-Stream master. A stereo pair
// is a two-beat packet: left beat tlast=0, right beat tlast=1.
//
// Ports
//   m00_axis_aclk     : sole clock
//   m00_axis_aresetn  : synchronous active-low reset
//   enable            : capture enable; low returns the FSM to SYNC
//   bclk/lrclk/sdata  : asynchronous I2S pins (bclk <= aclk/4)
//   m00_axis_t*       : AXI-Stream master (tstrb constant all-ones)
//   overflow          : sticky, a completed word was dropped on a full FIFO
//   drop_count        : saturating dropped-word count
//
// Build option
//   I2S_RX_STATS_EN   : when defined, drop_count is a 16-bit saturating
//                       counter; otherwise drop_count is tied to zero.
//
// FSM states
//   state | meaning
//   SYNC  | waiting for an lrclk transition to frame a slot
//   SHIFT | capturing slot bits 1..DATA_BITS into the shift register
//   DONE  | word captured, ignoring the rest of the slot
// ---------------------------------------------------------------------------
module i2s_rx_deserializer
    import i2s_rx_pkg::*;
#(
    parameter int DATA_BITS              = 24,
    parameter int FIFO_DEPTH             = 2,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              m00_axis_aclk,
    input  logic                              m00_axis_aresetn,
    input  logic                              enable,
    input  logic                              bclk,
    input  logic                              lrclk,
    input  logic                              sdata,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic [3:0]                        m00_axis_tstrb,
    output logic                              m00_axis_tlast,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic                              overflow,
    output logic [15:0]                       drop_count
);

    localparam int                CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_BITS - 1);
    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]    PTR_ONE  = (PTR_W + 1)'(1);

    // ------------------------------------------------------------------
    // Pin conditioning
    // ------------------------------------------------------------------
    logic bclk_rise;
    logic lrclk_s;
    logic sdata_s;

    i2s_rx_sync u_sync (
        .clk_i       (m00_axis_aclk),
        .rst_ni      (m00_axis_aresetn),
        .bclk_i      (bclk),
        .lrclk_i     (lrclk),
        .sdata_i     (sdata),
        .bclk_rise_o (bclk_rise),
        .lrclk_s_o   (lrclk_s),
        .sdata_s_o   (sdata_s)
    );

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   chan_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_next;
    logic                   aligned_q;
    logic                   lr_prev_q;
    logic                   lr_prev_vld_q;
    logic                   lr_change;
    logic                   push_q;
    logic [AXIS_WIDTH:0]    push_word_q;   // {tlast, tdata}

    // The first rise after reset only primes lr_prev_q; a level seen once
    // is not a transition.
    assign lr_change  = bclk_rise & lr_prev_vld_q & (lrclk_s != lr_prev_q);
    assign shift_next = {shift_q[DATA_BITS-2:0], sdata_s};

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            state_q       <= SYNC;
            cnt_q         <= '0;
            chan_q        <= CHAN_LEFT;
            shift_q       <= '0;
            aligned_q     <= 1'b0;
            lr_prev_q     <= 1'b0;
            lr_prev_vld_q <= 1'b0;
            push_q        <= 1'b0;
            push_word_q   <= '0;
        end else begin
            push_q <= 1'b0;

            // Word-select history keeps tracking while disabled so that a
            // re-enable frames on the very next real transition.
            if (bclk_rise) begin
                lr_prev_q     <= lrclk_s;
                lr_prev_vld_q <= 1'b1;
            end

            if (!enable) begin
                state_q   <= SYNC;
                aligned_q <= 1'b0;
            end else if (bclk_rise) begin
                unique case (state_q)
                    SYNC: begin
                        if (lr_change) begin
                            cnt_q   <= '0;
                            chan_q  <= lrclk_s;
                            state_q <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        shift_q <= shift_next;
                        if (cnt_q == LAST_CNT) begin
                            // Right words are held back until a left word
                            // has opened the pair.
                            if (chan_q == CHAN_LEFT || aligned_q) begin
                                push_q      <= 1'b1;
                                push_word_q <= {chan_q, AXIS_WIDTH'($signed(shift_next))};
                            end
                            if (chan_q == CHAN_LEFT) begin
                                aligned_q <= 1'b1;
                            end
                            state_q <= DONE;
                        end
                        // A transition on the LSB rise (slot exactly
                        // DATA_BITS wide) keeps the word above; earlier
                        // transitions discard the partial word.
                        if (lr_change) begin
                            cnt_q   <= '0;
                            chan_q  <= lrclk_s;
                            state_q <= SHIFT;
                        end
                    end
                    DONE: begin
                        if (lr_change) begin
                            cnt_q   <= '0;
                            chan_q  <= lrclk_s;
                            state_q <= SHIFT;
                        end
                    end
                    default: state_q <= SYNC;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [AXIS_WIDTH:0] fifo_mem_q [FIFO_DEPTH];
    logic [AXIS_WIDTH:0] fifo_head;
    logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_pop;
    logic                fifo_push;
    logic                fifo_drop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                        (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    assign fifo_pop   = !fifo_empty && m00_axis_tready;
    // A pop in the same cycle frees the slot even when full.
    assign fifo_push  = push_q && (!fifo_full || fifo_pop);
    assign fifo_drop  = push_q && fifo_full && !fifo_pop;
    assign fifo_head  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (fifo_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (fifo_drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge m00_axis_aclk) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_word_q;
        end
    end

    assign m00_axis_tvalid = !fifo_empty;
    assign m00_axis_tdata  = fifo_empty ? '0   : fifo_head[AXIS_WIDTH-1:0];
    assign m00_axis_tlast  = fifo_empty ? 1'b0 : fifo_head[AXIS_WIDTH];
    assign m00_axis_tstrb  = TSTRB_ALL;
    assign overflow        = overflow_q;

    // ------------------------------------------------------------------
    // Drop statistics
    // ------------------------------------------------------------------
`ifdef I2S_RX_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (fifo_drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'd0;
`endif

endmodule
